// File: rtl/mem_arb_pkg.sv
// Shared types, default bus widths and the round-robin pick helper for the
// SDRAM request arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 24;
    localparam int unsigned MEM_DATA_WIDTH = 16;

    // rr_pick works on a fixed-width request vector; callers zero-extend.
    localparam int unsigned RR_MAX_REQ = 8;
    localparam int unsigned RR_IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // First requesting index at or after ptr, wrapping modulo num_req.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           num_req,
        input int unsigned           ptr
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (!found && (i < num_req) && req[RR_IDX_W'(idx)]) begin
                pick  = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order FIFO of requester tags for reads issued but not yet completed.
module mem_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned TAG_W = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [TAG_W-1:0]          i_tag,
    output logic [TAG_W-1:0]          o_tag,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_tag     = r_mem[r_rd_ptr[PTR_W-1:0]];

    // A push while full is only legal when the head leaves the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_tag;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the mem_cntrl command port between requesters,
// with bounded bursts per grant and in-order routing of read completions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 3,
    parameter int unsigned ADDR_WIDTH      = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = MEM_DATA_WIDTH,
    parameter int unsigned BURST_MAX       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_r_en,
    input  logic [NUM_REQ-1:0]            req_w_en,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            req_cplt,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    output logic                          mem_r_en,
    output logic                          mem_w_en,
    input  logic [DATA_WIDTH-1:0]         mem_data_out,
    input  logic                          mem_rdy,
    input  logic                          mem_cplt,
    output logic                          err
);

    localparam int unsigned TAG_W  = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W = $clog2(BURST_MAX + 1);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e              r_state;
    logic [TAG_W-1:0]        r_grant;
    logic [TAG_W-1:0]        r_rr_ptr;
    logic [BCNT_W-1:0]       r_burst_cnt;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_data;
    logic                    r_mem_r_en;
    logic                    r_mem_w_en;

    logic [NUM_REQ-1:0]      w_req_vec;
    logic [TAG_W-1:0]        w_pick;
    logic [TAG_W-1:0]        w_sel;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_sel_w;
    logic                    w_sel_r;
    logic                    w_cmd_active;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_drop;
    logic                    w_burst_done;
    logic [TAG_W-1:0]        w_rr_next;
    logic [TAG_W-1:0]        w_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [CNT_W-1:0]        w_fifo_cnt;
    logic [CNT_W-1:0]        w_fifo_cnt_nxt;
    logic                    w_rd_room;

    assign w_req_vec  = req_r_en | req_w_en;
    assign w_pick     = TAG_W'(rr_pick(RR_MAX_REQ'(w_req_vec), NUM_REQ, 32'(r_rr_ptr)));

    // Source of the next registered command: the new winner in IDLE, else the holder.
    assign w_sel      = (r_state == IDLE) ? w_pick : r_grant;
    assign w_sel_addr = req_addr[32'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = req_data[32'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_w    = req_w_en[w_sel];
    assign w_sel_r    = req_r_en[w_sel] && !w_sel_w;

    assign w_cmd_active = r_mem_r_en || r_mem_w_en;
    assign w_accept     = mem_rdy && w_cmd_active;
    assign w_push       = w_accept && r_mem_r_en;
    assign w_pop        = mem_cplt && !w_fifo_empty;

    assign w_drop       = !(req_r_en[r_grant] || req_w_en[r_grant]);
    assign w_burst_done = w_accept && (r_burst_cnt == BCNT_W'(BURST_MAX - 1));
    assign w_rr_next    = (r_grant == TAG_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Look ahead to next-cycle occupancy so a registered read never overfills the FIFO.
    assign w_fifo_cnt_nxt = w_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_room      = (w_fifo_cnt_nxt < CNT_W'(MAX_OUTSTANDING));

    assign req_rdy     = w_accept ? (NUM_REQ'(1) << r_grant) : '0;
    assign req_cplt    = w_pop ? (NUM_REQ'(1) << w_head) : '0;
    assign rd_data     = mem_data_out;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data;
    assign mem_r_en    = r_mem_r_en;
    assign mem_w_en    = r_mem_w_en;
    assign err         = r_err;

    mem_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_tag   (r_grant),
        .o_tag   (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_r_en  <= 1'b0;
            r_mem_w_en  <= 1'b0;
        end else begin
            if ((mem_cplt && w_fifo_empty) || (mem_rdy && !w_cmd_active) ||
                (w_push && w_fifo_full && !w_pop)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_mem_r_en <= 1'b0;
                    r_mem_w_en <= 1'b0;
                    if (|w_req_vec) begin
                        r_state    <= GRANT;
                        r_grant    <= w_pick;
                        r_mem_addr <= w_sel_addr;
                        r_mem_data <= w_sel_data;
                        r_mem_w_en <= w_sel_w;
                        r_mem_r_en <= w_sel_r && w_rd_room;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                    if (w_drop || w_burst_done) begin
                        r_state     <= IDLE;
                        r_mem_r_en  <= 1'b0;
                        r_mem_w_en  <= 1'b0;
                        r_rr_ptr    <= w_rr_next;
                        r_burst_cnt <= '0;
                    end else begin
                        r_mem_addr <= w_sel_addr;
                        r_mem_data <= w_sel_data;
                        r_mem_w_en <= w_sel_w;
                        r_mem_r_en <= w_sel_r && w_rd_room;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_r_en <= 1'b0;
                    r_mem_w_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: rotation, burst limit, back-pressure,
// completion routing through a scoreboard queue, and error flagging.
module tb_mem_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_r_en;
    logic [NR-1:0]    req_w_en;
    logic [NR-1:0]    req_rdy;
    logic [NR-1:0]    req_cplt;
    logic [DW-1:0]    rd_data;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_data_in;
    logic             mem_r_en;
    logic             mem_w_en;
    logic [DW-1:0]    mem_data_out;
    logic             mem_rdy;
    logic             mem_cplt;
    logic             err;

    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];
    int unsigned cnt[NR];
    int          acc;
    int          n_cplt;
    int          owner;
    int          head;
    bit          phase;

    mem_arbiter #(
        .NUM_REQ         (NR),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BURST_MAX       (16),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_r_en     (req_r_en),
        .req_w_en     (req_w_en),
        .req_rdy      (req_rdy),
        .req_cplt     (req_cplt),
        .rd_data      (rd_data),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .mem_data_out (mem_data_out),
        .mem_rdy      (mem_rdy),
        .mem_cplt     (mem_cplt),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    function automatic logic [31:0] base_addr(input int i, input int unsigned n);
        return 32'((i + 1) * 32'h1000) + 32'(n);
    endfunction

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_r_en[i]         = r;
        req_w_en[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One clock: drive the controller side for this cycle, then let outputs settle.
    task automatic cyc(input logic rdy, input logic cplt, input logic [DW-1:0] dout);
        @(posedge clk);
        #1;
        mem_rdy      = rdy;
        mem_cplt     = cplt;
        mem_data_out = dout;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req_addr = '0;
        req_data = '0;
        req_r_en = '0;
        req_w_en = '0;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NR; i++) cnt[i] = 0;
    endtask

    initial begin
        mem_rdy = 1'b0; mem_cplt = 1'b0; mem_data_out = '0;

        // Reset state
        do_reset();
        chk("rst_r_en", 32'(mem_r_en), 0);
        chk("rst_w_en", 32'(mem_w_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_err",  32'(err), 0);
        chk("rst_rdy",  32'(req_rdy), 0);

        // Single write from requester 0
        set_req(0, 1'b0, 1'b1, 24'h000010, 16'hBEEF);
        cyc(1'b0, 1'b0, '0);
        chk("t1_w_en", 32'(mem_w_en), 1);
        chk("t1_r_en", 32'(mem_r_en), 0);
        chk("t1_addr", 32'(mem_addr), 32'h10);
        chk("t1_data", 32'(mem_data_in), 32'hBEEF);
        chk("t1_norr", 32'(req_rdy), 0);
        cyc(1'b1, 1'b0, '0);
        chk("t1_rdy", 32'(req_rdy), oh(0));
        set_req(0, 1'b0, 1'b0, 24'h000010, 16'hBEEF);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("t1_idle", 32'(mem_w_en), 0);
        chk("t1_err", 32'(err), 0);

        // Two continuous readers: 16-command bursts alternate 0 -> 1 -> 0
        do_reset();
        set_req(0, 1'b1, 1'b0, 24'(base_addr(0, 0)), '0);
        set_req(1, 1'b1, 1'b0, 24'(base_addr(1, 0)), '0);
        acc = 0; n_cplt = 0; phase = 1'b0;
        for (int c = 0; c < 400 && acc < 40; c++) begin
            @(posedge clk);
            #1;
            mem_rdy      = phase && mem_r_en;
            mem_cplt     = !phase && (exp_q.size() > 0);
            mem_data_out = 16'(32'h5A00 + n_cplt);
            #1;
            if (mem_rdy) begin
                owner = ((acc / 16) % 2 == 0) ? 0 : 1;
                chk("t2_rdy", 32'(req_rdy), oh(owner));
                chk("t2_addr", 32'(mem_addr), base_addr(owner, cnt[owner]));
                exp_q.push_back(owner);
                acc++;
            end else begin
                chk("t2_norr", 32'(req_rdy), 0);
            end
            if (mem_cplt) begin
                head = exp_q.pop_front();
                chk("t2_cplt", 32'(req_cplt), oh(head));
                chk("t2_rdata", 32'(rd_data), 32'h5A00 + 32'(n_cplt));
                n_cplt++;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_rdy[i]) begin
                    cnt[i]++;
                    req_addr[i*AW +: AW] = 24'(base_addr(i, cnt[i]));
                end
            end
            phase = !phase;
        end
        chk("t2_accepts", 32'(acc), 40);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, exp_q.size() > 0, 16'h7777);
            if (mem_cplt) begin
                head = exp_q.pop_front();
                chk("t2_drain", 32'(req_cplt), oh(head));
            end
        end
        chk("t2_empty", 32'(exp_q.size()), 0);
        chk("t2_err", 32'(err), 0);

        // Back-pressure at MAX_OUTSTANDING reads
        do_reset();
        set_req(0, 1'b1, 1'b0, 24'h000300, '0);
        acc = 0; phase = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            mem_rdy  = phase && mem_r_en;
            mem_cplt = 1'b0;
            #1;
            if (req_rdy[0]) begin
                acc++;
                exp_q.push_back(0);
                req_addr[0 +: AW] = 24'(32'h300 + 32'(acc));
            end
            phase = !phase;
        end
        chk("t3_accepts", 32'(acc), 4);
        chk("t3_stall", 32'(mem_r_en), 0);
        cyc(1'b0, 1'b1, 16'h3333);
        head = exp_q.pop_front();
        chk("t3_cplt", 32'(req_cplt), oh(head));
        cyc(1'b1, 1'b0, '0);
        chk("t3_resume", 32'(mem_r_en), 1);
        chk("t3_rdy5", 32'(req_rdy), oh(0));
        exp_q.push_back(0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 1'b1, 16'(32'h3400 + c));
            head = exp_q.pop_front();
            chk("t3_drain", 32'(req_cplt), oh(head));
        end
        chk("t3_err", 32'(err), 0);

        // Simultaneous accept and completion with two reads outstanding
        do_reset();
        set_req(0, 1'b1, 1'b0, 24'h000400, '0);
        cyc(1'b1, 1'b0, '0);
        chk("t4_rdy_a", 32'(req_rdy), oh(0));
        exp_q.push_back(0);
        req_addr[0 +: AW] = 24'h000401;
        cyc(1'b1, 1'b0, '0);
        chk("t4_rdy_b", 32'(req_rdy), oh(0));
        exp_q.push_back(0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 24'h000500, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 16'h4444);
        chk("t4_rdy_c", 32'(req_rdy), oh(1));
        exp_q.push_back(1);
        head = exp_q.pop_front();
        chk("t4_cplt_a", 32'(req_cplt), oh(head));
        chk("t4_rdata", 32'(rd_data), 32'h4444);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 16'h4445);
        head = exp_q.pop_front();
        chk("t4_cplt_b", 32'(req_cplt), oh(head));
        cyc(1'b0, 1'b1, 16'h4446);
        head = exp_q.pop_front();
        chk("t4_cplt_c", 32'(req_cplt), oh(head));
        chk("t4_noerr", 32'(err), 0);
        cyc(1'b0, 1'b1, 16'h4447);
        chk("t4_stray", 32'(req_cplt), 0);
        cyc(1'b0, 1'b0, '0);
        chk("t4_err", 32'(err), 1);

        // Read and write together resolve to a write
        do_reset();
        set_req(2, 1'b1, 1'b1, 24'h000222, 16'h1234);
        cyc(1'b0, 1'b0, '0);
        chk("t5_w_en", 32'(mem_w_en), 1);
        chk("t5_r_en", 32'(mem_r_en), 0);
        chk("t5_addr", 32'(mem_addr), 32'h222);
        cyc(1'b1, 1'b0, '0);
        chk("t5_rdy", 32'(req_rdy), oh(2));
        set_req(2, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 16'h5555);
        chk("t5_nocplt", 32'(req_cplt), 0);
        cyc(1'b0, 1'b0, '0);
        chk("t5_err", 32'(err), 1);

        // Reset mid-burst with three reads outstanding
        do_reset();
        set_req(0, 1'b1, 1'b0, 24'h000600, '0);
        acc = 0; phase = 1'b0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            @(posedge clk);
            #1;
            mem_rdy  = phase && mem_r_en;
            mem_cplt = 1'b0;
            #1;
            if (req_rdy[0]) begin
                acc++;
                req_addr[0 +: AW] = 24'(32'h600 + 32'(acc));
            end
            phase = !phase;
        end
        chk("t6_accepts", 32'(acc), 3);
        rst = 1'b1;
        cyc(1'b0, 1'b0, '0);
        chk("t6_r_en", 32'(mem_r_en), 0);
        chk("t6_w_en", 32'(mem_w_en), 0);
        chk("t6_addr", 32'(mem_addr), 0);
        chk("t6_data", 32'(mem_data_in), 0);
        chk("t6_err0", 32'(err), 0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 16'h6666);
        chk("t6_nocplt", 32'(req_cplt), 0);
        cyc(1'b0, 1'b0, '0);
        chk("t6_err1", 32'(err), 1);

        // mem_rdy with no command presented
        do_reset();
        cyc(1'b1, 1'b0, '0);
        chk("t7_norr", 32'(req_rdy), 0);
        cyc(1'b0, 1'b0, '0);
        chk("t7_err", 32'(err), 1);
        cyc(1'b0, 1'b0, '0);
        chk("t7_sticky", 32'(err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
